mult_seq_bcd: RTL and testbench
===============================

MULT_SEQ_BCD -- requirements
Module: mult_seq_bcd

Interface
REQ-001 The block SHALL have parameter N_BITS, default 8: operand magnitude width.
REQ-002 The block SHALL have parameter BCD_DIGITS, default 5: BCD digits of the product.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, all state on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port valid_in, input, 1 bit: upstream operands valid (level, may stay high indefinitely).
REQ-006 The block SHALL have ports numero1 and numero2, input, N_BITS each: unsigned operand magnitudes.
REQ-007 The block SHALL have ports signo1 and signo2, input, 1 bit each: operand signs, 1 = negative.
REQ-008 The block SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-009 The block SHALL have port producto, output, 2*N_BITS: product magnitude, binary.
REQ-010 The block SHALL have port bcd, output, 4*BCD_DIGITS: product magnitude as packed BCD, digit 0 in bits [3:0].
REQ-011 The block SHALL have port signo_res, output, 1 bit: product sign.
REQ-012 The block SHALL have port result_valid, output, 1 bit: one-cycle pulse, results updated.

Function
REQ-013 FSM states SHALL be IDLE, MULT, CONV, DONE.
REQ-014 Acceptance SHALL occur on the rising edge of valid_in, i.e. valid_in=1 with its registered previous value 0, in IDLE; that edge is E0.
REQ-015 At E0 the block SHALL register numero1, numero2, signo1, signo2, clear the accumulator and enter MULT.
REQ-016 valid_in rising edges outside IDLE SHALL be ignored, and a level held high SHALL NOT retrigger.
REQ-017 MULT SHALL perform one shift-add iteration per cycle on edges E1..E8 (N_BITS iterations) via a counter, then enter CONV.
REQ-018 CONV SHALL perform one double-dabble step per cycle on edges E9..E24 (2*N_BITS steps): add 3 to each digit >=5, then shift left.
REQ-019 On E24 the block SHALL load producto, bcd and signo_res, set result_valid and enter DONE.
REQ-020 In DONE, the next edge SHALL clear result_valid and return to IDLE, so result_valid is high exactly one cycle.
REQ-021 signo_res SHALL equal signo1 XOR signo2, forced to 0 when the product is 0.
REQ-022 Arithmetic SHALL be full-width and unsigned, with no truncation: 255*255=65025 fits in 16 bits and 5 digits.
REQ-023 producto, bcd and signo_res SHALL hold their last value until the next completion.

Reset
REQ-024 On rst low, the block SHALL immediately clear to IDLE with producto=0, bcd=0, signo_res=0, result_valid=0 and previous-valid register=0.
REQ-025 During reset ready SHALL be 1.
REQ-026 Reset mid-MULT or mid-CONV SHALL abort the operation with no result_valid pulse.
REQ-027 After reset release, a valid_in already high SHALL count as a rising edge.

Configuration
REQ-028 Macro MULT_SEQ_BCD_EN defined: CONV and the converter SHALL be present, with latency per REQ-019.
REQ-029 Macro MULT_SEQ_BCD_EN undefined: CONV SHALL be skipped, MULT SHALL go directly to DONE with results loaded on E8, and bcd SHALL be tied to 0.

Structure
REQ-030 Package mult_pkg SHALL hold the state enum typedef, N_BITS/BCD_DIGITS defaults, and the iteration-count constants.
REQ-031 The double-dabble datapath SHALL be sub-module bin2bcd_seq (start, load value, step, done), instantiated only under MULT_SEQ_BCD_EN.

Verification
REQ-032 12, 34, signs 0/0, valid_in pulse -> at E24 result_valid=1, producto=408, bcd=0x00408, signo_res=0.
REQ-033 12, 34, signs 1/0 -> producto=408, signo_res=1; signs 1/1 -> signo_res=0.
REQ-034 0 and 5, signs 0/1 -> producto=0, bcd=0, signo_res=0.
REQ-035 99*99 -> producto=9801, bcd=0x09801; 255*255 -> producto=65025, bcd=0x65025.
REQ-036 valid_in held high 100 cycles -> exactly one result_valid pulse; ready low from E1 until DONE exit.
REQ-037 rst low at E5 -> outputs 0 and ready=1 immediately, no result_valid pulse; a new valid_in edge then gives a correct result.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential signed-magnitude multiplier
// with optional binary-to-BCD conversion (enabled by MULT_SEQ_BCD_EN).
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      CONV = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int N_BITS_DEF     = 8;
   localparam int BCD_DIGITS_DEF = 5;

   // Shift-add iterations: one per multiplier bit.
   localparam int MULT_ITERS_DEF = N_BITS_DEF;
   // Double-dabble steps: one per product bit.
   localparam int CONV_STEPS_DEF = 2 * N_BITS_DEF;

   function automatic int mult_iters(input int n_bits);
      return n_bits;
   endfunction

   function automatic int conv_steps(input int n_bits);
      return 2 * n_bits;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: start loads a binary value, each step
// adds 3 to every digit >= 5 and shifts the whole register left by one bit.
// done flags the final step; bcd_nxt is the digit register after this step.
module bin2bcd_seq
   import mult_pkg::*;
#(
   parameter int BIN_W  = conv_steps(N_BITS_DEF),
   parameter int DIGITS = BCD_DIGITS_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      load_val,
   input  logic                  step,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_nxt
);

   localparam int CW = $clog2(BIN_W) + 1;

   logic [4*DIGITS-1:0] bcd_r;
   logic [4*DIGITS-1:0] adj;
   logic [BIN_W-1:0]    bin_r;
   logic [CW-1:0]       cnt;

   // Digit correction followed by the left shift that pulls in the next bit.
   always_comb begin
      adj = bcd_r;
      for (int d = 0; d < DIGITS; d++) begin
         if (adj[4*d +: 4] >= 4'd5)
            adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
      end
      bcd_nxt = {adj[4*DIGITS-2:0], bin_r[BIN_W-1]};
      done    = step && (cnt == CW'(BIN_W - 1));
   end

   // Shift register and step counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bcd_r <= '0;
         bin_r <= '0;
         cnt   <= '0;
      end else if (start) begin
         bcd_r <= '0;
         bin_r <= load_val;
         cnt   <= '0;
      end else if (step) begin
         bcd_r <= bcd_nxt;
         bin_r <= bin_r << 1;
         cnt   <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mult_seq_bcd.sv
// Sequential shift-add sign/magnitude multiplier. Accepts operands on a rising
// edge of valid_in while idle, produces the binary product after N_BITS
// cycles and, when MULT_SEQ_BCD_EN is defined, a packed-BCD copy after a
// further 2*N_BITS double-dabble steps. Without MULT_SEQ_BCD_EN the BCD
// converter is absent and bcd reads as 0.
module mult_seq_bcd
   import mult_pkg::*;
#(
   parameter int N_BITS     = N_BITS_DEF,
   parameter int BCD_DIGITS = BCD_DIGITS_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valid_in,
   input  logic [N_BITS-1:0]       numero1,
   input  logic [N_BITS-1:0]       numero2,
   input  logic                    signo1,
   input  logic                    signo2,
   output logic                    ready,
   output logic [2*N_BITS-1:0]     producto,
   output logic [4*BCD_DIGITS-1:0] bcd,
   output logic                    signo_res,
   output logic                    result_valid
);

   localparam int PW = 2 * N_BITS;
   localparam int CW = $clog2(N_BITS) + 1;

   state_t            state, state_nxt;
   logic              valid_q;
   logic [PW-1:0]     a_sh;
   logic [N_BITS-1:0] b_sh;
   logic              s1_q, s2_q;
   logic [PW-1:0]     acc, acc_nxt, res_val;
   logic [CW-1:0]     cnt;
   logic              start, mult_last, load, conv_done;

   assign start     = (state == IDLE) && valid_in && !valid_q;
   assign mult_last = (state == MULT) && (cnt == CW'(mult_iters(N_BITS) - 1));
   assign acc_nxt   = acc + (b_sh[0] ? a_sh : '0);
   assign ready     = (state == IDLE);

`ifdef MULT_SEQ_BCD_EN
   logic [4*BCD_DIGITS-1:0] conv_bcd;
   logic [4*BCD_DIGITS-1:0] bcd_q;

   // Converter is seeded with the final product on the last multiply edge.
   bin2bcd_seq #(.BIN_W(PW), .DIGITS(BCD_DIGITS)) u_conv (
      .clk      (clk),
      .rst      (rst),
      .start    (mult_last),
      .load_val (acc_nxt),
      .step     (state == CONV),
      .done     (conv_done),
      .bcd_nxt  (conv_bcd)
   );

   assign load    = conv_done;
   assign res_val = acc;

   // BCD result register, updated only on completion.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      bcd_q <= '0;
      else if (load) bcd_q <= conv_bcd;
   end

   assign bcd = bcd_q;
`else
   assign conv_done = 1'b0;
   assign load      = mult_last;
   assign res_val   = acc_nxt;
   assign bcd       = '0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = MULT;
`ifdef MULT_SEQ_BCD_EN
         MULT: if (mult_last) state_nxt = CONV;
`else
         MULT: if (mult_last) state_nxt = DONE;
`endif
         CONV: if (conv_done) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, shift-add datapath and result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q      <= 1'b0;
         a_sh         <= '0;
         b_sh         <= '0;
         s1_q         <= 1'b0;
         s2_q         <= 1'b0;
         acc          <= '0;
         cnt          <= '0;
         producto     <= '0;
         signo_res    <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         valid_q      <= valid_in;
         result_valid <= load;
         if (start) begin
            a_sh <= PW'(numero1);
            b_sh <= numero2;
            s1_q <= signo1;
            s2_q <= signo2;
            acc  <= '0;
            cnt  <= '0;
         end else if (state == MULT) begin
            acc  <= acc_nxt;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + 1'b1;
         end
         if (load) begin
            producto  <= res_val;
            // A zero product is always reported as positive.
            signo_res <= (s1_q ^ s2_q) && (res_val != '0);
         end
      end
   end

endmodule

// File: tb/tb_mult_seq_bcd.sv
// Self-checking bench for mult_seq_bcd: directed corner cases, randomized
// operands, held valid_in, and mid-operation reset, against a decimal
// reference model.
module tb_mult_seq_bcd;

   localparam int N = 8;
   localparam int D = 5;
`ifdef MULT_SEQ_BCD_EN
   localparam int LAT = 25;
   localparam bit HAS_BCD = 1'b1;
`else
   localparam int LAT = 9;
   localparam bit HAS_BCD = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           valid_in = 1'b0;
   logic [N-1:0]   numero1 = '0;
   logic [N-1:0]   numero2 = '0;
   logic           signo1 = 1'b0;
   logic           signo2 = 1'b0;
   logic           ready;
   logic [2*N-1:0] producto;
   logic [4*D-1:0] bcd;
   logic           signo_res;
   logic           result_valid;

   int checks = 0;
   int errors = 0;

   mult_seq_bcd #(.N_BITS(N), .BCD_DIGITS(D)) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_in     (valid_in),
      .numero1      (numero1),
      .numero2      (numero2),
      .signo1       (signo1),
      .signo2       (signo2),
      .ready        (ready),
      .producto     (producto),
      .bcd          (bcd),
      .signo_res    (signo_res),
      .result_valid (result_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: decimal digits of the product, digit 0 in the low nibble.
   function automatic logic [31:0] ref_bcd(input int v);
      logic [31:0] r = '0;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic issue(input int a, input int b, input bit s1, input bit s2);
      numero1  = N'(a);
      numero2  = N'(b);
      signo1   = s1;
      signo2   = s2;
      valid_in = 1'b1;
   endtask

   // Called at a negedge just after issue(); the next posedge is E0.
   task automatic collect(input int a, input int b, input bit s1, input bit s2);
      int lat = 0;
      int p   = a * b;
      for (int k = 1; k <= 60 && lat == 0; k++) begin
         @(posedge clk); @(negedge clk);
         if (k == 1) begin
            chk("ready_busy", 32'(ready), 32'd0);
            valid_in = 1'b0;
         end
         if (result_valid) lat = k;
      end
      chk("latency", lat, LAT);
      chk("ready_done", 32'(ready), 32'd0);
      chk("producto", 32'(producto), 32'(p));
      chk("bcd", 32'(bcd), HAS_BCD ? ref_bcd(p) : 32'd0);
      chk("signo_res", 32'(signo_res), 32'((s1 ^ s2) && p != 0));
      @(posedge clk); @(negedge clk);
      chk("rv_clear", 32'(result_valid), 32'd0);
      chk("ready_idle", 32'(ready), 32'd1);
      chk("producto_hold", 32'(producto), 32'(p));
   endtask

   task automatic do_op(input int a, input int b, input bit s1, input bit s2);
      @(negedge clk);
      issue(a, b, s1, s2);
      collect(a, b, s1, s2);
   endtask

   initial begin
      int pulses;
      // Reset state
      #12;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_prod", 32'(producto), 32'd0);
      chk("rst_bcd", 32'(bcd), 32'd0);
      chk("rst_sign", 32'(signo_res), 32'd0);
      chk("rst_rv", 32'(result_valid), 32'd0);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);

      // Directed cases
      do_op(12, 34, 0, 0);
      do_op(12, 34, 1, 0);
      do_op(12, 34, 1, 1);
      do_op(0, 5, 0, 1);
      do_op(99, 99, 0, 0);
      do_op(255, 255, 1, 0);
      do_op(1, 1, 0, 1);

      // Randomized operands
      for (int i = 0; i < 25; i++)
         do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               1'($urandom), 1'($urandom));

      // Level held high must trigger exactly once
      @(negedge clk);
      issue(77, 200, 0, 1);
      pulses = 0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); @(negedge clk);
         if (result_valid) pulses++;
      end
      chk("hold_pulses", pulses, 1);
      chk("hold_prod", 32'(producto), 32'(77 * 200));
      chk("hold_ready", 32'(ready), 32'd1);
      valid_in = 1'b0;
      @(negedge clk);

      // Reset in the middle of MULT
      issue(200, 150, 1, 0);
      repeat (6) begin @(posedge clk); @(negedge clk); valid_in = 1'b0; end
      rst = 1'b0;
      #1;
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_prod", 32'(producto), 32'd0);
      chk("abort_bcd", 32'(bcd), 32'd0);
      chk("abort_sign", 32'(signo_res), 32'd0);
      pulses = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); @(negedge clk);
         if (result_valid) pulses++;
      end
      chk("abort_no_rv", pulses, 0);

      // valid_in already high at reset release counts as an edge
      issue(123, 45, 0, 1);
      rst = 1'b1;
      collect(123, 45, 0, 1);
      do_op(250, 4, 1, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
